// File: rtl/spidergon_vc_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spidergon_vc_allocator_pkg
//  Purpose  : Shared NoC definitions for the spidergon router: flit type
//             codes, header field widths and the index-width helper used to
//             size VC and requester index fields.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spidergon_vc_allocator_pkg;

    // Index width for a field that selects one of 'value' items. Never
    // returns 0, so a single-item field still has one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Two-bit flit type carried in every flit. HEADER is a single-flit
    // packet, so it both claims and releases a VC.
    typedef enum logic [1:0] {
        TAIL_FLIT = 2'b00,
        HEAD_FLIT = 2'b01,
        BODY_FLIT = 2'b10,
        HEADER    = 2'b11
    } flit_type_e;

    localparam int HEAD_TAIL       = 2;
    localparam int SPIDERGON_NODES = 8;
    localparam int DEST_NODE_WIDTH = clog2_min1(SPIDERGON_NODES);

endpackage : spidergon_vc_allocator_pkg
`default_nettype wire

// File: rtl/spidergon_vc_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module   : spidergon_vc_allocator_if
//  Purpose  : Request/grant bundle between the input ports of one spidergon
//             router and the VC allocator of one output port.
//  Signals  : req        - level, head flit waiting for a VC (per requester)
//             release_vc - 1-cycle pulse, tail/HEADER flit has left
//                          ('release' is a reserved word, hence the name)
//             grant      - one-hot (or zero) 1-cycle grant pulse
//             grant_vc   - VC index per requester, valid with grant and held
//             holding    - requester currently owns a VC
//             vc_busy    - VC currently owned
//  Modports : master (input-port side), slave (allocator)
//  Revision : 1.0 - initial release
// ============================================================================
interface spidergon_vc_allocator_if
    import spidergon_vc_allocator_pkg::*;
#(
    parameter int NUM_OF_REQUESTERS       = 4,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2
) ();

    localparam int VC_W = clog2_min1(NUM_OF_VIRTUAL_CHANNELS);

    logic [NUM_OF_REQUESTERS-1:0]        req;
    logic [NUM_OF_REQUESTERS-1:0]        release_vc;
    logic [NUM_OF_REQUESTERS-1:0]        grant;
    logic [NUM_OF_REQUESTERS*VC_W-1:0]   grant_vc;
    logic [NUM_OF_REQUESTERS-1:0]        holding;
    logic [NUM_OF_VIRTUAL_CHANNELS-1:0]  vc_busy;

    modport master (
        output req, release_vc,
        input  grant, grant_vc, holding, vc_busy
    );

    modport slave (
        input  req, release_vc,
        output grant, grant_vc, holding, vc_busy
    );

endinterface : spidergon_vc_allocator_if
`default_nettype wire

// File: rtl/spidergon_vc_allocator_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spidergon_vc_allocator_rr_arbiter
//  Purpose  : Purely combinational round-robin arbiter. Picks the first
//             asserted request at or after ptr, wrapping around. The pointer
//             register itself lives in the allocator.
//  Ports    : req     in  N       request vector
//             ptr     in  PTR_W   highest-priority index this cycle
//             gnt     out N       one-hot winner (zero when no request)
//             gnt_idx out PTR_W   binary index of the winner
//  Revision : 1.0 - initial release
// ============================================================================
module spidergon_vc_allocator_rr_arbiter
    import spidergon_vc_allocator_pkg::*;
#(
    parameter  int N     = 4,
    localparam int PTR_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = PTR_W'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

endmodule : spidergon_vc_allocator_rr_arbiter
`default_nettype wire

// File: rtl/spidergon_vc_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : spidergon_vc_allocator
//  Purpose  : Allocates the virtual channels of one spidergon output port to
//             the clockwise, anticlockwise, across and local input ports.
//             Round-robin over requesters, lowest-index-first over free VCs,
//             at most one grant per cycle, one cycle from req to grant.
//             A VC stays owned until its owner pulses release_vc.
//  Ports    : clk    in  clock
//             reset  in  synchronous, active-high reset
//             bus    slave modport of spidergon_vc_allocator_if
//  Revision : 1.0 - initial release
// ============================================================================
module spidergon_vc_allocator
    import spidergon_vc_allocator_pkg::*;
#(
    parameter int NUM_OF_REQUESTERS       = 4,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    spidergon_vc_allocator_if.slave bus
);

    localparam int NR    = NUM_OF_REQUESTERS;
    localparam int NV    = NUM_OF_VIRTUAL_CHANNELS;
    localparam int VC_W  = clog2_min1(NV);
    localparam int REQ_W = clog2_min1(NR);
    localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(NR - 1);

    logic [NR-1:0]      r_grant;
    logic [NR*VC_W-1:0] r_grant_vc;
    logic [NR-1:0]      r_holding;
    logic [NV-1:0]      r_vc_busy;
    logic [REQ_W-1:0]   r_ptr;
    logic [REQ_W-1:0]   r_owner [NV];

    logic [NR-1:0]      w_eligible;
    logic [NR-1:0]      w_arb_gnt;
    logic [REQ_W-1:0]   w_arb_idx;
    logic [NV-1:0]      w_free_oh;
    logic [VC_W-1:0]    w_free_idx;
    logic               w_do_grant;
    logic [NR-1:0]      w_rel;
    logic [NV-1:0]      w_freed;
    logic [NR-1:0]      w_holding_nxt;
    logic [NV-1:0]      w_vc_busy_nxt;

    // A requester that already owns a VC is never eligible, even if its
    // req lags the grant by a cycle or it re-requests while releasing.
    assign w_eligible = bus.req & ~r_holding;

    spidergon_vc_allocator_rr_arbiter #(
        .N (NR)
    ) u_rr_arbiter (
        .req     (w_eligible),
        .ptr     (r_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx)
    );

    // Lowest-index free VC, judged on the busy state at cycle start, so a
    // VC freed on this edge is only offered to the next decision.
    always_comb begin
        w_free_oh  = '0;
        w_free_idx = '0;
        for (int v = NV - 1; v >= 0; v--) begin
            if (!r_vc_busy[v]) begin
                w_free_oh    = '0;
                w_free_oh[v] = 1'b1;
                w_free_idx   = VC_W'(v);
            end
        end
    end

    assign w_do_grant = (|w_eligible) && (|w_free_oh);

    // Releases from requesters that hold nothing are dropped here.
    assign w_rel = bus.release_vc & r_holding;

    // The owner table maps each busy VC back to its requester, so a release
    // frees exactly the VC that requester was granted.
    always_comb begin
        w_freed = '0;
        for (int v = 0; v < NV; v++) begin
            w_freed[v] = r_vc_busy[v] & w_rel[r_owner[v]];
        end
    end

    // Grant and release never touch the same bit: the winner holds nothing
    // and the chosen VC is free, while releases only clear owned state.
    assign w_holding_nxt = (r_holding & ~w_rel)     | (w_do_grant ? w_arb_gnt : '0);
    assign w_vc_busy_nxt = (r_vc_busy & ~w_freed)   | (w_do_grant ? w_free_oh : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant    <= '0;
            r_grant_vc <= '0;
            r_holding  <= '0;
            r_vc_busy  <= '0;
            r_ptr      <= '0;
            for (int v = 0; v < NV; v++) begin
                r_owner[v] <= '0;
            end
        end else begin
            r_grant   <= w_do_grant ? w_arb_gnt : '0;
            r_holding <= w_holding_nxt;
            r_vc_busy <= w_vc_busy_nxt;
            if (w_do_grant) begin
                r_ptr <= (w_arb_idx == LAST_REQ) ? '0 : w_arb_idx + 1'b1;
            end
            // grant_vc doubles as the per-requester held-VC record: it only
            // changes on a new grant to that requester.
            for (int i = 0; i < NR; i++) begin
                if (w_do_grant && w_arb_gnt[i]) begin
                    r_grant_vc[i*VC_W +: VC_W] <= w_free_idx;
                end
            end
            for (int v = 0; v < NV; v++) begin
                if (w_do_grant && w_free_oh[v]) begin
                    r_owner[v] <= w_arb_idx;
                end
            end
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_vc = r_grant_vc;
    assign bus.holding  = r_holding;
    assign bus.vc_busy  = r_vc_busy;

endmodule : spidergon_vc_allocator
`default_nettype wire

// File: tb/tb_spidergon_vc_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spidergon_vc_allocator
//  Purpose  : Self-checking bench for spidergon_vc_allocator. Instance u_a is
//             the 4-requester / 2-VC configuration, u_b the 1-VC one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spidergon_vc_allocator;

    localparam int BOUND = 40;

    logic clk;
    logic rst_a;
    logic rst_b;

    spidergon_vc_allocator_if #(.NUM_OF_REQUESTERS(4), .NUM_OF_VIRTUAL_CHANNELS(2)) ifa ();
    spidergon_vc_allocator_if #(.NUM_OF_REQUESTERS(4), .NUM_OF_VIRTUAL_CHANNELS(1)) ifb ();

    spidergon_vc_allocator #(.NUM_OF_REQUESTERS(4), .NUM_OF_VIRTUAL_CHANNELS(2)) u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    spidergon_vc_allocator #(.NUM_OF_REQUESTERS(4), .NUM_OF_VIRTUAL_CHANNELS(1)) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] rel;
        logic [3:0] grant;
        logic [3:0] gv;
        logic [3:0] holding;
        logic [1:0] busy;
    } vec_t;

    vec_t vecs [20];

    int n_checks = 0;
    int n_err    = 0;

    // random-phase model state
    logic [3:0] prev_req, prev_rel, elig, hold_m, hold_start, new_req, new_rel;
    logic [1:0] busy_exp;
    logic       dup;
    int         hold_cnt [4];
    int         wait_cnt [4];
    int         max_wait;
    int         win;
    int         exp_w;
    logic       got;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //          rst   req      rel      grant    gv       holding  busy
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00};
        vecs[1]  = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 2'b01};
        vecs[2]  = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'b01};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b00};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 2'b01};
        vecs[6]  = '{1'b0, 4'b1110, 4'b0000, 4'b0010, 4'b0010, 4'b0011, 2'b11};
        vecs[7]  = '{1'b0, 4'b1100, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 2'b11};
        vecs[8]  = '{1'b0, 4'b1100, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 2'b10};
        vecs[9]  = '{1'b0, 4'b1100, 4'b0000, 4'b0100, 4'b0010, 4'b0110, 2'b11};
        vecs[10] = '{1'b0, 4'b1000, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 2'b01};
        vecs[11] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b1010, 4'b1100, 2'b11};
        vecs[12] = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b1010, 4'b1100, 2'b11};
        vecs[13] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 4'b1010, 4'b0100, 2'b01};
        vecs[14] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b1010, 4'b1100, 2'b11};
        vecs[15] = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b1010, 4'b1000, 2'b10};
        vecs[16] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b1000, 4'b1010, 2'b11};
        vecs[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00};
        vecs[18] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 2'b01};
        vecs[19] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1001, 2'b11};

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.req = '0; ifa.release_vc = '0;
        ifb.req = '0; ifb.release_vc = '0;
        step();
        step();
        rst_b = 1'b0;

        // ---------------- directed table on the 2-VC instance ----------------
        for (int i = 0; i < 20; i++) begin
            rst_a          = vecs[i].rst;
            ifa.req        = vecs[i].req;
            ifa.release_vc = vecs[i].rel;
            step();
            chk($sformatf("v%0d_grant", i),    ifa.grant,    vecs[i].grant);
            chk($sformatf("v%0d_grant_vc", i), ifa.grant_vc, vecs[i].gv);
            chk($sformatf("v%0d_holding", i),  ifa.holding,  vecs[i].holding);
            chk($sformatf("v%0d_vc_busy", i),  ifa.vc_busy,  vecs[i].busy);
        end
        rst_a = 1'b0;
        ifa.req = '0;
        ifa.release_vc = '0;

        // ---------------- round-robin fairness with a single VC -------------
        chk("rr_reset_holding", ifb.holding, 4'b0000);
        chk("rr_reset_busy",    ifb.vc_busy, 1'b0);
        ifb.req = 4'b0110;
        exp_w = 1;
        for (int g = 0; g < 8; g++) begin
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                step();
                if (ifb.grant != 4'b0000) got = 1'b1;
            end
            chk($sformatf("rr_grant_seen_%0d", g), got, 1'b1);
            chk($sformatf("rr_winner_%0d", g), ifb.grant, 4'(1 << exp_w));
            chk($sformatf("rr_grant_vc_%0d", g), ifb.grant_vc, 4'b0000);
            win = (ifb.grant == 4'b0100) ? 2 : 1;
            step();
            ifb.release_vc = 4'(1 << win);
            step();
            ifb.release_vc = '0;
            chk($sformatf("rr_released_%0d", g), ifb.holding, 4'b0000);
            exp_w = 3 - exp_w;
        end
        ifb.req = '0;

        // ---------------- random traffic on the 2-VC instance ---------------
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        hold_m = '0;
        max_wait = 0;
        for (int i = 0; i < 4; i++) begin
            hold_cnt[i] = 0;
            wait_cnt[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            step();
            prev_req   = ifa.req;
            prev_rel   = ifa.release_vc;
            hold_start = hold_m;
            elig       = prev_req & ~hold_start;
            hold_m     = hold_m & ~prev_rel;

            chk("rand_grant_legal",
                32'($onehot0(ifa.grant) && ((ifa.grant & ~elig) == 4'b0000)), 32'd1);
            chk("rand_grant_when_possible", 32'(|ifa.grant),
                32'((elig != 4'b0000) && ($countones(hold_start) < 2)));

            for (int i = 0; i < 4; i++) begin
                if (ifa.grant[i]) begin
                    hold_cnt[i] = $urandom_range(4, 1);
                    wait_cnt[i] = 0;
                end
            end
            hold_m = hold_m | ifa.grant;
            chk("rand_holding", ifa.holding, hold_m);

            busy_exp = '0;
            dup = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (hold_m[i]) begin
                    if (busy_exp[ifa.grant_vc[i]]) dup = 1'b1;
                    busy_exp[ifa.grant_vc[i]] = 1'b1;
                end
            end
            chk("rand_no_shared_vc", dup, 1'b0);
            chk("rand_vc_busy", ifa.vc_busy, busy_exp);
            chk("rand_popcount", $countones(ifa.holding), $countones(ifa.vc_busy));

            new_req = prev_req & ~ifa.grant;
            new_rel = '0;
            for (int i = 0; i < 4; i++) begin
                if (hold_m[i] && !ifa.grant[i]) begin
                    if (hold_cnt[i] == 0) begin
                        new_rel[i] = 1'b1;
                        if ($urandom_range(1, 0) == 1) new_req[i] = 1'b1;
                    end else begin
                        hold_cnt[i]--;
                    end
                end else if (!hold_m[i] && !new_req[i]) begin
                    if ($urandom_range(2, 0) == 0) new_req[i] = 1'b1;
                    else if ($urandom_range(15, 0) == 0) new_rel[i] = 1'b1;
                end
                if (new_req[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            ifa.req        = new_req;
            ifa.release_vc = new_rel;
        end
        chk("rand_starvation_bound", 32'(max_wait <= BOUND), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_spidergon_vc_allocator
`default_nettype wire
